// File: rtl/bm_memory_stream_reader_if.sv
// ---------------------------------------------------------------------------
// bm_memory_stream_reader_if
//
// Bundles the write port and the valid/ready drain stream of
// bm_memory_stream_reader.
//
// Signals:
//   wr_en, wr_addr, wr_data  external write port into the reader's memory
//   start                    request a drain pass (honoured only when idle)
//   out_data, out_valid,     registered output stream; out_last marks the
//   out_last, out_ready      word read from the highest address
//   busy, done               pass in progress / one-cycle end-of-pass pulse
//
// Modports:
//   master  the environment: writer, pass initiator and stream consumer
//   slave   the reader itself
// ---------------------------------------------------------------------------
interface bm_memory_stream_reader_if #(
    parameter int unsigned BITS      = 2,
    parameter int unsigned ADDR_BITS = 2
);
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [BITS-1:0]      wr_data;
    logic                 start;
    logic [BITS-1:0]      out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output start,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_last,
        input  busy,
        input  done
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  start,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_last,
        output busy,
        output done
    );
endinterface

// File: rtl/bm_memory_stream_reader.sv
// ---------------------------------------------------------------------------
// bm_memory_stream_reader
//
// Holds a 2^ADDR_BITS x BITS register memory filled through a plain write
// port. On start it drains every entry, lowest address first, through a
// registered valid/ready stream, then pulses done for one cycle.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  synchronous, active-low reset (memory contents are not cleared)
//   bus      bm_memory_stream_reader_if.slave: write port, start, output
//            stream (out_data/out_valid/out_ready/out_last), busy, done
//
// Build option:
//   BM_MEM_READER_LOOP_EN  when defined, accepting the last word while start
//                          is high restarts the pass at address 0 without a
//                          done pulse, giving a continuous stream.
// ---------------------------------------------------------------------------
module bm_memory_stream_reader #(
    parameter int unsigned BITS      = 2,
    parameter int unsigned ADDR_BITS = 2
) (
    input logic                      clock,
    input logic                      reset_n,
    bm_memory_stream_reader_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPresent,
        StDone
    } state_e;

    logic [BITS-1:0] mem [DEPTH];

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [BITS-1:0]      out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;

    // Writes land on the edge; a FETCH on the same edge therefore still reads
    // the previous contents (read-before-write).
    always_ff @(posedge clock) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rd_addr_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StFetch;
                    rd_addr_d = '0;
                end
            end

            StFetch: begin
                out_data_d  = mem[rd_addr_q];
                out_valid_d = 1'b1;
                out_last_d  = (rd_addr_q == LAST_ADDR);
                state_d     = StPresent;
            end

            StPresent: begin
                // Stream outputs stay frozen until the consumer takes the word.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (!out_last_q) begin
                        rd_addr_d = rd_addr_q + 1'b1;
                        state_d   = StFetch;
                    end else begin
`ifdef BM_MEM_READER_LOOP_EN
                        if (bus.start) begin
                            rd_addr_d = '0;
                            state_d   = StFetch;
                        end else begin
                            state_d = StDone;
                        end
`else
                        state_d = StDone;
`endif
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);

    // A word is on the stream exactly while the FSM is presenting it.
    a_valid_in_present : assert property (
        @(posedge clock) disable iff (!reset_n) out_valid_q == (state_q == StPresent)
    );

    a_done_not_valid : assert property (
        @(posedge clock) disable iff (!reset_n) (state_q == StDone) |-> !out_valid_q
    );
endmodule

// File: tb/tb_bm_memory_stream_reader.sv
module tb_bm_memory_stream_reader;
    localparam int unsigned BITS      = 2;
    localparam int unsigned ADDR_BITS = 2;
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    bm_memory_stream_reader_if #(.BITS(BITS), .ADDR_BITS(ADDR_BITS)) bus ();

    bm_memory_stream_reader #(.BITS(BITS), .ADDR_BITS(ADDR_BITS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the pass, built from the observable rules: a pass
    // starts on a start seen while idle; the first word appears one edge
    // later, each accepted non-last word is followed one edge later by the
    // next word, the value shown is the memory content before that edge's
    // write, and the edge after the last accept is the single done cycle.
    int              m_phase = 0;  // 0 idle, 1 draining, 2 done cycle
    logic            m_valid = 1'b0;
    logic            m_pend  = 1'b0;
    logic            m_last  = 1'b0;
    int              m_k     = 0;
    logic [BITS-1:0] m_word  = '0;
    logic [BITS-1:0] m_mem [DEPTH];
    int              passes_done = 0;

    task automatic tick();
        logic                 e_rst, e_start, e_ready, e_wen, acc;
        logic [ADDR_BITS-1:0] e_waddr;
        logic [BITS-1:0]      e_wdata;
        e_rst   = reset_n;
        e_start = bus.start;
        e_ready = bus.out_ready;
        e_wen   = bus.wr_en;
        e_waddr = bus.wr_addr;
        e_wdata = bus.wr_data;
        @(posedge clock);
        #1;
        acc = m_valid && e_ready;
        if (!e_rst) begin
            m_phase = 0;
            m_valid = 1'b0;
            m_pend  = 1'b0;
            m_last  = 1'b0;
            m_k     = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (e_start) begin
                        m_phase = 1;
                        m_pend  = 1'b1;
                        m_k     = 0;
                    end
                end
                1: begin
                    if (m_pend) begin
                        m_pend  = 1'b0;
                        m_valid = 1'b1;
                        m_word  = m_mem[m_k];
                        m_last  = (m_k == int'(DEPTH) - 1);
                    end else if (acc) begin
                        m_valid = 1'b0;
                        if (!m_last) begin
                            m_k++;
                            m_pend = 1'b1;
`ifdef BM_MEM_READER_LOOP_EN
                        end else if (e_start) begin
                            m_k    = 0;
                            m_pend = 1'b1;
`endif
                        end else begin
                            m_phase = 2;
                        end
                    end
                end
                default: begin
                    m_phase = 0;
                    passes_done++;
                end
            endcase
        end
        if (e_wen) m_mem[e_waddr] = e_wdata;

        check("model_valid", 32'(bus.out_valid), 32'(m_valid));
        check("model_busy", 32'(bus.busy), 32'(m_phase != 0));
        check("model_done", 32'(bus.done), 32'(m_phase == 2));
        if (m_valid) begin
            check("model_data", 32'(bus.out_data), 32'(m_word));
            check("model_last", 32'(bus.out_last), 32'(m_last));
        end
        if (!e_rst) begin
            check("model_rst_data", 32'(bus.out_data), 32'd0);
            check("model_rst_last", 32'(bus.out_last), 32'd0);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        bus.wr_en     = 1'b0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(bus.busy), 32'd0);
    endtask

    typedef struct {
        logic            rst_n;
        logic            start;
        logic            ready;
        logic            exp_valid;
        logic [BITS-1:0] exp_data;
        logic            exp_last;
        logic            exp_busy;
        logic            exp_done;
    } vec_t;

    vec_t vecs [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int done_seen;

        // Inputs applied before an edge; expectations checked just after it.
        // Memory holds 0,1,2,3 and the reader is idle before row 0.
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

        reset_n       = 1'b0;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;

        // Reset held for two cycles with start and out_ready high.
        tick();
        tick();
        check("reset_valid", 32'(bus.out_valid), 32'd0);
        check("reset_last", 32'(bus.out_last), 32'd0);
        check("reset_data", 32'(bus.out_data), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);

        reset_n   = 1'b1;
        bus.start = 1'b0;
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_BITS'(a);
            bus.wr_data = BITS'(a);
            tick();
        end
        bus.wr_en = 1'b0;

        // Basic drain, back-pressure on word 2, restart after done, mid-pass reset.
        for (int i = 0; i < 19; i++) begin
            reset_n       = vecs[i].rst_n;
            bus.start     = vecs[i].start;
            bus.out_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].exp_done));
            if (vecs[i].exp_valid || !vecs[i].rst_n) begin
                check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
                check($sformatf("vec%0d_last", i), 32'(bus.out_last), 32'(vecs[i].exp_last));
            end
        end

        // Collision: write 3 to address 1 on the edge that fetches address 1.
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 2'd3;
        tick();
        bus.wr_en = 1'b0;
        check("collision_old", 32'(bus.out_data), 32'd1);
        drain("collision_drain1");
        tick();

        // Second pass sees the new value; a write to the shown address leaves it alone.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.out_ready = 1'b0;
        tick();
        check("collision_new", 32'(bus.out_data), 32'd3);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_data = 2'd0;
        tick();
        bus.wr_en = 1'b0;
        check("presented_stable", 32'(bus.out_data), 32'd3);
        check("presented_valid", 32'(bus.out_valid), 32'd1);
        drain("collision_drain2");
        tick();

`ifdef BM_MEM_READER_LOOP_EN
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_BITS'(a);
            bus.wr_data = BITS'(a);
            tick();
        end
        bus.wr_en     = 1'b0;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        idx           = 0;
        done_seen     = 0;
        for (int c = 0; c < 60 && (c == 0 || bus.busy); c++) begin
            tick();
            if (bus.out_valid) begin
                check("loop_data", 32'(bus.out_data), 32'(idx % int'(DEPTH)));
                idx++;
            end
            if (bus.done) done_seen++;
            if (idx == int'(DEPTH) + 2) bus.start = 1'b0;
        end
        check("loop_words", 32'(idx), 32'(2 * DEPTH));
        check("loop_done_count", 32'(done_seen), 32'd1);
        bus.start = 1'b0;
        tick();
`else
        idx       = 0;
        done_seen = 0;
`endif

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset_n       = ($urandom_range(0, 199) != 0);
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.wr_en     = ($urandom_range(0, 2) == 0);
            bus.wr_addr   = ADDR_BITS'($urandom_range(0, DEPTH - 1));
            bus.wr_data   = BITS'($urandom);
            tick();
        end
        reset_n = 1'b1;
        drain("final_drain");
        check("passes_seen", 32'(passes_done > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
